sim_monitor: RTL
================

# sim_monitor

Parametrised, synthesizable test monitor that sits beside the `cpu`/`datamem` pair in the top-level bench and snoops the CPU data-memory bus. It counts run cycles, detects a tohost-style completion write to a magic address (pass or fail with code), enforces a cycle-budget timeout, and buffers a trace of memory writes in a FIFO for the bench to drain. It replaces fixed-length clocking with a self-terminating, self-checking run.

## Interface
- DATA_W, 32, data bus width
- ADDR_W, 32, address bus width
- TOHOST_ADDR, 32'h0000_FFFC, completion mailbox address (full-width compare)
- MAX_CYCLES, 1000, run-cycle budget before timeout (must be ≥2)
- TRACE_DEPTH, 8, write-trace FIFO entries (power of two, ≥2)
- CNT_W, 32, cycle counter width

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous active-low reset (asserts immediately, releases synchronously to clk)
- start  in  1  begin run; sampled only in IDLE
- memwrite  in  1  CPU store strobe
- mem_addr  in  ADDR_W  CPU memory address
- mem_writedata  in  DATA_W  CPU store data
- done  out  1  run finished (PASS, FAIL or TIMEOUT); sticky
- pass  out  1  run finished with pass
- timeout  out  1  run finished by budget exhaustion
- fail_code  out  DATA_W  tohost value on FAIL, else 0
- cycle_count  out  CNT_W  completed RUN cycles
- trace_valid  out  1  FIFO non-empty
- trace_addr  out  ADDR_W  head entry address
- trace_data  out  DATA_W  head entry data
- trace_pop  in  1  consume head entry
- trace_overflow  out  1  sticky: a write was dropped

## Operation
- States: IDLE, RUN, PASS, FAIL, TIMEOUT. Reset → IDLE.
- IDLE: start=1 → RUN next edge; counter held at 0.
- RUN: cycle_count += 1 each edge.
  - memwrite=1 and mem_addr==TOHOST_ADDR: data==1 → PASS; other nonzero → FAIL, fail_code←data; data==0 ignored (stay RUN).
  - Else if cycle_count==MAX_CYCLES-1 → TIMEOUT.
  - Tohost completion and budget expiry on the same cycle: completion wins.
- PASS/FAIL/TIMEOUT: terminal until reset; counter frozen; start ignored.
- done = state ∈ {PASS,FAIL,TIMEOUT}; pass = PASS; timeout = TIMEOUT.
- Trace FIFO: every RUN-state memwrite (including tohost writes) pushes {mem_addr, mem_writedata}. No pushes outside RUN.
  - Push when full and no pop: entry dropped, trace_overflow set (sticky until reset).
  - Push and pop same cycle when full: both happen, no overflow.
  - Pop when empty: ignored, no pointer change.
  - trace_addr/trace_data show head entry; 0 when empty.
  - Pop remains functional in terminal states (bench drains after done).
- Counter saturates at all-ones if CNT_W is too narrow for MAX_CYCLES.

## Timing
- Reset values: state IDLE, done 0, pass 0, timeout 0, fail_code 0, cycle_count 0, trace_valid 0, trace_addr 0, trace_data 0, trace_overflow 0, FIFO empty.
- Reset assertion mid-run: all outputs return to reset values immediately (asynchronously), FIFO contents discarded.
- start high at edge E → RUN after E; first increment at E+1.
- Tohost write sampled at edge N → done/pass/fail_code valid after N; cycle_count after N includes cycle N.
- Timeout: done after the edge at which cycle_count goes MAX_CYCLES-1 → MAX_CYCLES; cycle_count reads MAX_CYCLES.
- FIFO: push at edge N → trace_valid=1 after N (1-cycle latency); pop at edge M → next head visible after M.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Reset then start; stores to 0x10 (data 5), 0x14 (data 7), then tohost=1 on run cycle 10 → done=1, pass=1, cycle_count=10, FIFO drains (0x10,5),(0x14,7),(0xFFFC,1), trace_overflow=0.
- Tohost=0x0000_002A on run cycle 4 → done=1, pass=0, timeout=0, fail_code=0x2A; later tohost=1 ignored.
- MAX_CYCLES=20, no tohost write → timeout=1 after cycle_count reaches 20; tohost=1 on exactly cycle 20 in a second run → pass=1, timeout=0.
- TRACE_DEPTH=8, 10 stores with no pop → 8 entries retained (first 8), trace_overflow=1; with full FIFO, simultaneous push+pop → count stays 8, overflow unchanged; pop on empty → no change.
- Assert reset mid-run at cycle 5 with 3 entries queued → all outputs 0 immediately; restart → cycle_count from 0, FIFO empty.
- Stores before start and after done → not traced, no state change.

Source files
------------

// File: rtl/sim_monitor.sv
// Bench-side run monitor: counts RUN cycles, watches the tohost mailbox, enforces a cycle budget, traces stores.
// Latency: status and trace outputs update one edge after the sampled bus cycle. Completion is visible after the tohost edge.
// Backpressure: none on the CPU bus. Trace pushes into a full FIFO are dropped and flagged unless a pop happens in the same cycle.
module sim_monitor #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 'h0000_FFFC,
  parameter int unsigned       MAX_CYCLES  = 1000,
  parameter int unsigned       TRACE_DEPTH = 8,
  parameter int unsigned       CNT_W       = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              memwrite_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_writedata_i,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic [DATA_W-1:0] fail_code_o,
  output logic [CNT_W-1:0]  cycle_count_o,
  output logic              trace_valid_o,
  output logic [ADDR_W-1:0] trace_addr_o,
  output logic [DATA_W-1:0] trace_data_o,
  input  logic              trace_pop_i,
  output logic              trace_overflow_o
);

  localparam int unsigned AW = $clog2(TRACE_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_e;

  // The reset synchronizer clears at once but releases only after two clock edges.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Reset synchronizer: asserts asynchronously and releases on clk.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  fail_code_q;
  logic               done_q, pass_q, timeout_q;
  logic               tohost_hit, budget_hit;

  // A tohost write of 0 is not a completion, so budget expiry still applies on that cycle.
  assign tohost_hit = memwrite_i && (mem_addr_i == TOHOST_ADDR) && (mem_writedata_i != '0);
  assign budget_hit = (64'(cnt_q) == (64'(MAX_CYCLES) - 64'd1));

  // Run-control FSM with registered status flags, cycle counter and fail code.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      fail_code_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (start_i) state_q <= S_RUN;
        end
        S_RUN: begin
          if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
          if (tohost_hit) begin
            done_q <= 1'b1;
            if (mem_writedata_i == DATA_W'(1)) begin
              state_q <= S_PASS;
              pass_q  <= 1'b1;
            end else begin
              state_q     <= S_FAIL;
              fail_code_q <= mem_writedata_i;
            end
          end else if (budget_hit) begin
            state_q   <= S_TIMEOUT;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign done_o        = done_q;
  assign pass_o        = pass_q;
  assign timeout_o     = timeout_q;
  assign fail_code_o   = fail_code_q;
  assign cycle_count_o = cnt_q;

  // Trace FIFO: pointers carry one wrap bit to tell full from empty.
  logic [AW:0]               wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [ADDR_W+DATA_W-1:0]  mem_q [TRACE_DEPTH];
  logic                      overflow_q;
  logic                      empty, full, push_req, push_en, pop_en;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_req = (state_q == S_RUN) && memwrite_i;
  assign pop_en   = trace_pop_i && !empty;
  assign push_en  = push_req && (!full || pop_en);
  assign wr_ptr_d = push_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = pop_en  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  // Pointer and sticky overflow update.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_req && full && !pop_en) overflow_q <= 1'b1;
    end
  end

  // Storage needs no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= {mem_addr_i, mem_writedata_i};
  end

  assign trace_valid_o    = !empty;
  assign trace_overflow_o = overflow_q;
  assign {trace_addr_o, trace_data_o} = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule
